// File: rtl/f1_reaction_timer_if.sv
// Bus between the CPU-side light pattern / driver button and the F1 reaction timer.
// Carries best_time only when F1_BEST_TIME_EN is defined.
interface f1_reaction_timer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]  a0;
  logic                   btn;
  logic [COUNT_WIDTH-1:0] reaction_time;
  logic                   result_valid;
  logic                   timeout;
  logic                   jump_start;
  logic                   busy;
`ifdef F1_BEST_TIME_EN
  logic [COUNT_WIDTH-1:0] best_time;

  modport master (
    output a0, btn,
    input  reaction_time, result_valid, timeout, jump_start, busy, best_time
  );
  modport slave (
    input  a0, btn,
    output reaction_time, result_valid, timeout, jump_start, busy, best_time
  );
`else
  modport master (
    output a0, btn,
    input  reaction_time, result_valid, timeout, jump_start, busy
  );
  modport slave (
    input  a0, btn,
    output reaction_time, result_valid, timeout, jump_start, busy
  );
`endif
endinterface

// File: rtl/f1_reaction_timer.sv
// F1 start-light reaction timer: follows the light-up sequence on a0[7:0], times the button after lights out.
// Optional best-lap register enabled by defining F1_BEST_TIME_EN.
module f1_reaction_timer #(
  parameter int DATA_WIDTH  = 32,
  parameter int TICK_DIV    = 1000,
  parameter int COUNT_WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  f1_reaction_timer_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]          PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMING = 3'd1;
  localparam logic [2:0] S_LIT    = 3'd2;
  localparam logic [2:0] S_TIMING = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [7:0]             last_q, last_d;
  logic                   btn_meta_q, btn_meta_d;
  logic                   btn_sync_q, btn_sync_d;
  logic                   btn_prev_q, btn_prev_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] rt_q, rt_d;
  logic                   rv_q, rv_d;
  logic                   to_q, to_d;
  logic                   js_q, js_d;
  logic                   busy_q, busy_d;

  logic [7:0] p_s;
  logic [7:0] next_s;
  logic       press_s;
  logic       tick_s;
  logic       cnt_sat_s;
  logic       unused_a0_s;

  assign p_s         = bus.a0[7:0];
  assign unused_a0_s = ^bus.a0[DATA_WIDTH-1:8];
  assign next_s      = {last_q[6:0], 1'b1};
  assign press_s     = btn_sync_q & ~btn_prev_q;
  assign tick_s      = (presc_q == PRESC_MAX);
  assign cnt_sat_s   = (cnt_q == CNT_MAX);

  always_comb begin
    state_d    = state_q;
    last_d     = p_s;
    btn_meta_d = bus.btn;
    btn_sync_d = btn_meta_q;
    btn_prev_d = btn_sync_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    rt_d       = rt_q;
    rv_d       = 1'b0;
    to_d       = to_q;

    case (state_q)
      S_IDLE: begin
        if (p_s == 8'h01) state_d = S_ARMING;
        else              state_d = S_IDLE;
      end
      S_ARMING: begin
        if (press_s)                              state_d = S_FAULT;
        else if (p_s == 8'hFF)                    state_d = S_LIT;
        else if (p_s == last_q || p_s == next_s)  state_d = S_ARMING;
        else                                      state_d = S_IDLE;
      end
      S_LIT: begin
        if (press_s) begin
          state_d = S_FAULT;
        end else if (p_s == 8'h00) begin
          state_d = S_TIMING;
          presc_d = {PW{1'b0}};
          cnt_d   = {COUNT_WIDTH{1'b0}};
        end else if (p_s == 8'hFF) begin
          state_d = S_LIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TIMING: begin
        if (tick_s) begin
          presc_d = {PW{1'b0}};
          if (!cnt_sat_s) cnt_d = cnt_q + 1'b1;
          else            cnt_d = cnt_q;
        end else begin
          presc_d = presc_q + 1'b1;
          cnt_d   = cnt_q;
        end
        // A press in a wrap cycle captures the count from before that tick.
        if (press_s) begin
          state_d = S_DONE;
          rt_d    = cnt_q;
          rv_d    = 1'b1;
          to_d    = cnt_sat_s;
        end else if (cnt_sat_s) begin
          state_d = S_DONE;
          rt_d    = CNT_MAX;
          rv_d    = 1'b1;
          to_d    = 1'b1;
        end else if (p_s != 8'h00) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_TIMING;
        end
      end
      S_DONE: begin
        if (p_s == 8'h01) begin
          state_d = S_ARMING;
          to_d    = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_FAULT: begin
        if (p_s == 8'h01) state_d = S_ARMING;
        else              state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_ARMING) || (state_d == S_LIT) || (state_d == S_TIMING);
    js_d   = (state_d == S_FAULT);
  end

`ifdef F1_BEST_TIME_EN
  logic [COUNT_WIDTH-1:0] best_q, best_d;

  always_comb begin
    if (rv_d && !to_d && (rt_d < best_q)) best_d = rt_d;
    else                                  best_d = best_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) best_q <= CNT_MAX;
    else      best_q <= best_d;
  end

  assign bus.best_time = best_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      last_q     <= 8'h00;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
      presc_q    <= {PW{1'b0}};
      cnt_q      <= {COUNT_WIDTH{1'b0}};
      rt_q       <= {COUNT_WIDTH{1'b0}};
      rv_q       <= 1'b0;
      to_q       <= 1'b0;
      js_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      btn_prev_q <= btn_prev_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      rt_q       <= rt_d;
      rv_q       <= rv_d;
      to_q       <= to_d;
      js_q       <= js_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.reaction_time = rt_q;
  assign bus.result_valid  = rv_q;
  assign bus.timeout       = to_q;
  assign bus.jump_start    = js_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Bench for f1_reaction_timer (TICK_DIV=4, COUNT_WIDTH=8): behavioural model compared every cycle,
// plus literal expectations for the documented scenarios. Best-time checks under F1_BEST_TIME_EN.
module tb_f1_reaction_timer;

  localparam int TDIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  f1_reaction_timer_if #(.DATA_WIDTH(32), .COUNT_WIDTH(8)) bus ();

  f1_reaction_timer #(.DATA_WIDTH(32), .TICK_DIV(TDIV), .COUNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: phase of the start procedure, button history and elapsed clocks since lights out.
  typedef enum int {M_IDLE, M_ARM, M_LIT, M_TIME, M_DONE, M_FAULT} mph_e;
  typedef struct {
    mph_e       ph;
    logic [7:0] last;
    logic [2:0] hist;
    int         elapsed;
    logic [7:0] rt;
    logic       rv;
    logic       to;
    logic       js;
    logic       busy;
    logic [7:0] best;
  } m_t;

  m_t m;

  function automatic m_t model_step(m_t s, logic rst_n, logic [7:0] p, logic b);
    m_t   n;
    logic press;
    logic [7:0] grow;
    int   ticks;
    n = s;
    if (!rst_n) begin
      n.ph = M_IDLE; n.last = 8'h00; n.hist = 3'b000; n.elapsed = 0;
      n.rt = 8'h00; n.rv = 1'b0; n.to = 1'b0; n.js = 1'b0; n.busy = 1'b0; n.best = 8'hFF;
      return n;
    end
    // A press is a 0->1 of the button as seen three and two clocks back.
    press = s.hist[1] & ~s.hist[2];
    grow  = 8'((int'(s.last) * 2 + 1) % 256);
    n.rv  = 1'b0;
    case (s.ph)
      M_IDLE:  if (p == 8'h01) n.ph = M_ARM;
      M_ARM: begin
        if (press) n.ph = M_FAULT;
        else if (p == 8'hFF) n.ph = M_LIT;
        else if (p == s.last || p == grow) n.ph = M_ARM;
        else n.ph = M_IDLE;
      end
      M_LIT: begin
        if (press) n.ph = M_FAULT;
        else if (p == 8'h00) begin n.ph = M_TIME; n.elapsed = 0; end
        else if (p != 8'hFF) n.ph = M_IDLE;
      end
      M_TIME: begin
        ticks = s.elapsed / TDIV;
        if (ticks > 255) ticks = 255;
        if (press) begin
          n.ph = M_DONE; n.rt = 8'(ticks); n.rv = 1'b1; n.to = (ticks == 255);
        end else if (ticks == 255) begin
          n.ph = M_DONE; n.rt = 8'hFF; n.rv = 1'b1; n.to = 1'b1;
        end else if (p != 8'h00) n.ph = M_IDLE;
        else n.elapsed = s.elapsed + 1;
        if (n.rv && !n.to && n.rt < s.best) n.best = n.rt;
      end
      M_DONE:  if (p == 8'h01) begin n.ph = M_ARM; n.to = 1'b0; end
      M_FAULT: if (p == 8'h01) n.ph = M_ARM;
      default: n.ph = M_IDLE;
    endcase
    n.hist = {s.hist[1:0], b};
    n.last = p;
    n.busy = (n.ph == M_ARM) || (n.ph == M_LIT) || (n.ph == M_TIME);
    n.js   = (n.ph == M_FAULT);
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m, rst, bus.a0[7:0], bus.btn);

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    check("m_result_valid",  32'(bus.result_valid),  32'(m.rv));
    check("m_reaction_time", 32'(bus.reaction_time), 32'(m.rt));
    check("m_timeout",       32'(bus.timeout),       32'(m.to));
    check("m_jump_start",    32'(bus.jump_start),    32'(m.js));
    check("m_busy",          32'(bus.busy),          32'(m.busy));
`ifdef F1_BEST_TIME_EN
    check("m_best_time",     32'(bus.best_time),     32'(m.best));
`endif
  end

  task automatic cyc(input logic [7:0] p, input logic b);
    bus.a0  = {24'($urandom()), p};
    bus.btn = b;
    @(negedge clk);
  endtask

  task automatic lights_out();
    for (int k = 1; k <= 8; k++) cyc(8'((1 << k) - 1), 1'b0);
    cyc(8'h00, 1'b0);
  endtask

  task automatic press_after(input int w, output logic got, output logic [7:0] rt, output logic to);
    got = 1'b0; rt = 8'h00; to = 1'b0;
    repeat (w) cyc(8'h00, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cyc(8'h00, k < 4);
      if (!got && bus.result_valid) begin
        got = 1'b1; rt = bus.reaction_time; to = bus.timeout;
      end
    end
  endtask

  initial begin
    logic       got;
    logic [7:0] rt;
    logic       to;
    int         kind, w;
    logic [7:0] p;

    bus.a0 = 32'h0; bus.btn = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rv",   32'(bus.result_valid), 32'd0);
    check("rst_rt",   32'(bus.reaction_time), 32'd0);
    check("rst_js",   32'(bus.jump_start), 32'd0);
    check("rst_to",   32'(bus.timeout), 32'd0);
    rst = 1'b1;
    cyc(8'h00, 1'b0);

    // Normal run: press about 40 clocks after lights out.
    lights_out();
    press_after(38, got, rt, to);
    check("norm_valid", 32'(got), 32'd1);
    check("norm_rt",    32'(rt),  32'd10);
    check("norm_to",    32'(to),  32'd0);

    // Jump start while 0x3F is showing.
    cyc(8'h01, 1'b0); cyc(8'h03, 1'b0); cyc(8'h07, 1'b0); cyc(8'h0F, 1'b0); cyc(8'h1F, 1'b0);
    repeat (4) cyc(8'h3F, 1'b1);
    repeat (2) cyc(8'h3F, 1'b0);
    check("js_set",  32'(bus.jump_start), 32'd1);
    check("js_busy", 32'(bus.busy), 32'd0);
    cyc(8'h01, 1'b0);
    check("js_clear",  32'(bus.jump_start), 32'd0);
    check("js_rearm",  32'(bus.busy), 32'd1);

    // Timeout: lights out and never press.
    lights_out();
    got = 1'b0;
    for (int k = 0; k < 1100 && !got; k++) begin
      cyc(8'h00, 1'b0);
      if (bus.result_valid) begin got = 1'b1; rt = bus.reaction_time; to = bus.timeout; end
    end
    check("to_valid", 32'(got), 32'd1);
    check("to_rt",    32'(rt),  32'hFF);
    check("to_flag",  32'(to),  32'd1);

    // Bad sequence drops back to idle, then a good run still measures.
    cyc(8'h01, 1'b0); cyc(8'h03, 1'b0); cyc(8'h0A, 1'b0);
    check("bad_busy", 32'(bus.busy), 32'd0);
    check("bad_to",   32'(bus.timeout), 32'd0);
    lights_out();
    press_after(20, got, rt, to);
    check("bad_then_valid", 32'(got), 32'd1);
    check("bad_then_rt",    32'(rt),  32'd5);

    // Reset in the middle of timing.
    lights_out();
    repeat (10) cyc(8'h00, 1'b0);
    rst = 1'b0;
    cyc(8'h00, 1'b0);
    rst = 1'b1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_rt",   32'(bus.reaction_time), 32'd0);
    check("mid_rst_rv",   32'(bus.result_valid), 32'd0);
    press_after(5, got, rt, to);
    check("mid_rst_no_result", 32'(got), 32'd0);

`ifdef F1_BEST_TIME_EN
    rst = 1'b0; cyc(8'h00, 1'b0); rst = 1'b1;
    check("best_reset", 32'(bus.best_time), 32'hFF);
    lights_out(); press_after(46, got, rt, to);
    check("best_12", 32'(bus.best_time), 32'd12);
    lights_out(); press_after(34, got, rt, to);
    check("best_9", 32'(bus.best_time), 32'd9);
    lights_out(); press_after(58, got, rt, to);
    check("best_15_keeps_9", 32'(bus.best_time), 32'd9);
`endif

    // Randomised runs: stray presses, corrupted patterns, aborts and resets.
    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 9));
      for (int k = 1; k <= 8; k++) begin
        p = 8'((1 << k) - 1);
        repeat (int'($urandom_range(1, 2))) cyc(p, (kind == 0) && ($urandom_range(0, 7) == 0));
        if (kind == 1 && k == 4) cyc(8'($urandom_range(2, 254)), 1'b0);
      end
      cyc(8'h00, 1'b0);
      w = int'($urandom_range(0, 80));
      for (int k = 0; k < w; k++) cyc((kind == 2 && k == w / 2) ? 8'h03 : 8'h00, 1'b0);
      repeat (4) cyc(8'h00, 1'b1);
      repeat (3) cyc(8'h00, 1'b0);
      if (kind == 3) begin
        rst = 1'b0; cyc(8'h00, 1'b0); rst = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
